// File: rtl/act_lut_pkg.sv
// Shared types and default geometry for the activation LUT reader.
package act_lut_pkg;

   localparam int unsigned DefaultDataW = 8;
   localparam int unsigned DefaultFrac  = 4;
   localparam int unsigned DefaultAddrW = 4;

   typedef enum logic [2:0] {
      StIdle,
      StRdB,
      StRdN,
      StCalc,
      StOut
   } state_e;

endpackage

// File: rtl/lut_linear_interp.sv
// Combinational linear interpolation between two signed table samples.
module lut_linear_interp
   import act_lut_pkg::*;
#(
   parameter int unsigned DATA_W = DefaultDataW,
   parameter int unsigned FRAC   = DefaultFrac
) (
   input  logic [DATA_W-1:0] base_i,
   input  logic [DATA_W-1:0] next_i,
   input  logic [FRAC-1:0]   rem_i,
   output logic [DATA_W-1:0] y_o
);

   localparam int unsigned ProdW = DATA_W + FRAC + 2;

   logic signed [DATA_W:0]  diff;
   logic signed [ProdW-1:0] diff_x;
   logic signed [ProdW-1:0] rem_x;
   logic signed [ProdW-1:0] base_x;
   logic signed [ProdW-1:0] prod;

   // One extra bit keeps next-base from wrapping when the samples straddle zero.
   assign diff   = $signed({next_i[DATA_W-1], next_i}) - $signed({base_i[DATA_W-1], base_i});
   assign diff_x = {{(ProdW-DATA_W-1){diff[DATA_W]}}, diff};
   assign rem_x  = {{(ProdW-FRAC){1'b0}}, rem_i};
   assign base_x = {{(ProdW-DATA_W){base_i[DATA_W-1]}}, base_i};
   assign prod   = diff_x * rem_x;

   // Result lies between base and next, so dropping the upper bits is exact.
   assign y_o = DATA_W'(base_x + (prod >>> FRAC));

endmodule

// File: rtl/act_lut_reader.sv
// Activation LUT front end: splits x into index/remainder, reads a synchronous table and
// returns y. Define ACT_LUT_INTERP_EN for linear interpolation; otherwise nearest-lower lookup.
module act_lut_reader
   import act_lut_pkg::*;
#(
   parameter int unsigned DATA_W = DefaultDataW,
   parameter int unsigned FRAC   = DefaultFrac,
   parameter int unsigned ADDR_W = DefaultAddrW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_x,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_y,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [DATA_W-1:0] y_q, y_d;
   logic [ADDR_W-1:0] in_idx;

   // Offset binary: the most negative x maps to entry 0.
   assign in_idx = {~in_x[DATA_W-1], in_x[DATA_W-2:FRAC]};

`ifdef ACT_LUT_INTERP_EN
   logic [ADDR_W-1:0] nidx_q, nidx_d;
   logic [FRAC-1:0]   rem_q, rem_d;
   logic [DATA_W-1:0] base_q, base_d;
   logic [DATA_W-1:0] interp_y;

   lut_linear_interp #(
      .DATA_W (DATA_W),
      .FRAC   (FRAC)
   ) u_interp (
      .base_i (base_q),
      .next_i (mem_rdata),
      .rem_i  (rem_q),
      .y_o    (interp_y)
   );
`else
   logic unused_rem;
   assign unused_rem = ^in_x[FRAC-1:0];
`endif

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      y_d       = y_q;
`ifdef ACT_LUT_INTERP_EN
      nidx_d    = nidx_q;
      rem_d     = rem_q;
      base_d    = base_q;
`endif
      in_ready  = 1'b0;
      out_valid = 1'b0;
      mem_en    = 1'b0;
      mem_addr  = '0;

      unique case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_d = StRdB;
               idx_d   = in_idx;
`ifdef ACT_LUT_INTERP_EN
               // Top entry has no successor; reuse it rather than wrapping to entry 0.
               nidx_d  = (&in_idx) ? in_idx : in_idx + ADDR_W'(1);
               rem_d   = in_x[FRAC-1:0];
`endif
            end
         end
         StRdB: begin
            mem_en   = 1'b1;
            mem_addr = idx_q;
`ifdef ACT_LUT_INTERP_EN
            state_d  = StRdN;
`else
            state_d  = StCalc;
`endif
         end
         StRdN: begin
`ifdef ACT_LUT_INTERP_EN
            mem_en   = 1'b1;
            mem_addr = nidx_q;
            base_d   = mem_rdata;
            state_d  = StCalc;
`else
            state_d  = StIdle;
`endif
         end
         StCalc: begin
            // The next sample is consumed straight off the read port in this cycle.
`ifdef ACT_LUT_INTERP_EN
            y_d     = interp_y;
`else
            y_d     = mem_rdata;
`endif
            state_d = StOut;
         end
         StOut: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
         y_q     <= '0;
`ifdef ACT_LUT_INTERP_EN
         nidx_q  <= '0;
         rem_q   <= '0;
         base_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         y_q     <= y_d;
`ifdef ACT_LUT_INTERP_EN
         nidx_q  <= nidx_d;
         rem_q   <= rem_d;
         base_q  <= base_d;
`endif
      end
   end

   assign out_y = y_q;

endmodule

// File: tb/tb_act_lut_reader.sv
// Self-checking bench for act_lut_reader with a timeline model of each transaction.
module tb_act_lut_reader;

`ifdef ACT_LUT_INTERP_EN
   localparam int LAT    = 4;
   localparam bit INTERP = 1'b1;
`else
   localparam int LAT    = 3;
   localparam bit INTERP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_x;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_y;
   logic       mem_en;
   logic [3:0] mem_addr;
   logic [7:0] mem_rdata = 8'h00;

   logic signed [7:0] tbl [16];

   int total = 0;
   int bad   = 0;

   bit m_on     = 1'b0;
   bit m_busy   = 1'b0;
   int m_age    = 0;
   int m_y      = 0;
   int m_prev_y = 0;
   int m_idx    = 0;
   int m_nidx   = 0;

   act_lut_reader dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .mem_en    (mem_en),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_en) mem_rdata <= tbl[mem_addr];
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   function automatic int f_idx(input logic [7:0] x);
      return (int'($signed(x)) >>> 4) + 8;
   endfunction

   function automatic int f_nidx(input logic [7:0] x);
      int i;
      i = f_idx(x);
      return (i < 15) ? i + 1 : 15;
   endfunction

   function automatic int f_y(input logic [7:0] x);
      int b, nx, r;
      b  = int'(tbl[f_idx(x)]);
      nx = int'(tbl[f_nidx(x)]);
      r  = int'(x & 8'h0F);
      if (INTERP) return b + (((nx - b) * r) >>> 4);
      return b;
   endfunction

   // Compare process: check outputs mid-cycle, then advance the model by the upcoming edge.
   initial begin
      forever begin
         @(negedge clk);
         if (m_on) begin
            chk("in_ready", int'(in_ready), int'(!m_busy));
            chk("out_valid", int'(out_valid), int'(m_busy && m_age >= LAT));
            chk("out_y", int'($signed(out_y)), (m_busy && m_age >= LAT) ? m_y : m_prev_y);
            chk("mem_en", int'(mem_en), int'(m_busy && (m_age == 1 || (INTERP && m_age == 2))));
            if (m_busy && m_age == 1) chk("mem_addr_base", int'(mem_addr), m_idx);
            if (INTERP && m_busy && m_age == 2) chk("mem_addr_next", int'(mem_addr), m_nidx);
         end
         if (rst) begin
            m_on     = 1'b1;
            m_busy   = 1'b0;
            m_age    = 0;
            m_prev_y = 0;
         end else if (m_on) begin
            if (!m_busy) begin
               if (in_valid) begin
                  m_busy = 1'b1;
                  m_age  = 1;
                  m_idx  = f_idx(in_x);
                  m_nidx = f_nidx(in_x);
                  m_y    = f_y(in_x);
               end
            end else if (m_age < LAT) begin
               m_age++;
            end else if (out_ready) begin
               m_busy   = 1'b0;
               m_prev_y = m_y;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [7:0] x, output int y, output int lat, output int waits);
      in_x     = x;
      in_valid = 1'b1;
      waits    = 0;
      while (!in_ready && waits < 20) begin
         tick();
         waits++;
      end
      chk("accept_ready", int'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      lat      = 1;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      y = int'($signed(out_y));
   endtask

   logic [7:0] vx   [6] = '{8'h00, 8'h18, 8'hF8, 8'hBC, 8'h7F, 8'h80};
   int         vy_i [6] = '{0, 12, -4, 50, 56, -64};
   int         vy_n [6] = '{0, 8, -8, -100, 56, -64};

   initial begin
      int y, lat, waits;
      for (int k = 0; k < 16; k++) tbl[k] = 8'(8 * k - 64);
      tbl[3] = -8'sd100;
      tbl[4] = 8'sd100;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_x      = 8'h00;
      out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_y", int'(out_y), 0);
      chk("rst_mem_en", int'(mem_en), 0);
      chk("rst_mem_addr", int'(mem_addr), 0);

      for (int i = 0; i < 6; i++) begin
         send(vx[i], y, lat, waits);
         chk($sformatf("lat_%02h", vx[i]), lat, LAT);
         chk($sformatf("y_%02h", vx[i]), y, INTERP ? vy_i[i] : vy_n[i]);
         tick();
      end

      // Stall in OUT for three cycles.
      out_ready = 1'b0;
      send(8'h18, y, lat, waits);
      for (int c = 0; c < 3; c++) begin
         chk("stall_valid", int'(out_valid), 1);
         chk("stall_y", int'($signed(out_y)), INTERP ? 12 : 8);
         chk("stall_in_ready", int'(in_ready), 0);
         chk("stall_mem_en", int'(mem_en), 0);
         if (c < 2) tick();
      end
      out_ready = 1'b1;
      send(8'h7F, y, lat, waits);
      chk("b2b_waits", waits, 1);
      chk("b2b_y", y, 56);

      // Abort a transaction with reset partway through the reads.
      in_x     = 8'h18;
      in_valid = 1'b1;
      waits    = 0;
      tick();
      while (!in_ready && waits < 20) begin
         tick();
         waits++;
      end
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_in_ready", int'(in_ready), 1);
      chk("abort_out_valid", int'(out_valid), 0);
      chk("abort_out_y", int'(out_y), 0);
      chk("abort_mem_en", int'(mem_en), 0);

      send(8'h18, y, lat, waits);
      chk("post_abort_lat", lat, LAT);
      chk("post_abort_y", y, INTERP ? 12 : 8);
      tick();
      tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
